sr_latch_ctrl: RTL and testbench
================================

// Module: sr_latch_ctrl
// PURPOSE
//  Synchronous sequencer that owns the S/R inputs of one active-high SR latch and shares it among
//  N_REQ requesters. Round-robin arbitration, fixed-width set/reset pulses, recovery gap.
//  By construction S=R=1 (the invalid latch state) is never driven.
//  Sits between control agents and the latch cell.
// PARAMETERS
//  N_REQ    4  number of requesters (2..16)
//  PULSE_W  2  cycles latch_s/latch_r is held high per op (>=1)
//  GAP_W    1  cycles both latch inputs are held low after a pulse (>=1)
//  IDW      clog2(N_REQ), localparam, width of grant_id
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      async active-low reset
//  req       in   N_REQ  per-requester request; held until own ack
//  op        in   N_REQ  per-requester op: 1=set (Q->1), 0=reset (Q->0); valid while req high
//  ack       out  N_REQ  one-hot, 1-cycle completion pulse to granted requester
//  latch_s   out  1      registered S drive to latch
//  latch_r   out  1      registered R drive to latch
//  busy      out  1      high in PULSE and RECOVER
//  grant_id  out  IDW    index of current/last winner
//  q_shadow  out  1      expected latch Q, updated at end of each pulse
//  latch_q   in   1      latch Q readback (only with SR_READBACK_CHECK_EN)
//  err       out  1      sticky mismatch flag (only with SR_READBACK_CHECK_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; state=IDLE; rr_ptr=0; pulse/gap counters 0.
//   Outputs drop immediately, mid-operation included. The in-flight op is abandoned, no ack.
//  FSM states: IDLE -> PULSE -> RECOVER -> IDLE.
//  IDLE: if |req, pick the first set bit scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   Register grant_id and op[winner]. Next state PULSE. rr_ptr <= winner+1 mod N_REQ.
//   If no req, stay in IDLE; outputs hold at 0.
//  PULSE: drive latch_s=op_q, latch_r=~op_q for exactly PULSE_W cycles.
//   On the last PULSE cycle: q_shadow <= op_q. Then go to RECOVER.
//  RECOVER: latch_s=latch_r=0 for GAP_W cycles. ack[grant_id]=1 in the last RECOVER cycle only.
//   Then go to IDLE.
//  Latency: req seen in IDLE cycle t -> drive cycles t+1..t+PULSE_W -> ack at t+PULSE_W+GAP_W.
//   Throughput is one op per 1+PULSE_W+GAP_W cycles.
//  Handshake: requester drops req no later than the cycle after ack.
//   A req still high in that IDLE cycle is a new request.
//   A req dropped after grant does not cancel the op; it completes and ack still pulses.
//   op changes after grant are ignored (latched at grant).
//  Redundant ops (op == q_shadow) are still pulsed and acked; there is no skip.
//  Simultaneous set and reset requests: resolved by arbitration only. The winner executes
//   fully, the loser waits. latch_s & latch_r == 0 on every cycle (assertion required).
//  New req arriving during PULSE/RECOVER waits. Arbitration happens only in IDLE.
//  Single requester holding req continuously: re-granted every 1+PULSE_W+GAP_W cycles.
// CONFIGURATION
//  SR_READBACK_CHECK_EN defined: latch_q/err ports exist.
//   latch_q is sampled in the first RECOVER cycle; err <= 1 if latch_q != q_shadow.
//   err is sticky until rst_n. The op is acked regardless.
//  SR_READBACK_CHECK_EN undefined: latch_q/err ports absent; no check logic.
//   All other behaviour is identical.
// TESTING (N_REQ=4, PULSE_W=2, GAP_W=1)
//  Reset: rst_n=0 -> latch_s=latch_r=busy=q_shadow=0, ack=0000.
//   Release, no req -> all stay 0.
//  Single set: req=0001, op=0001 at cycle 0 -> latch_s=1 cycles 1-2, q_shadow=1 from cycle 3,
//   ack=0001 at cycle 3, busy 1..3.
//  Contention: req=1111, op=0101 held, each requester drops req after own ack.
//   Grants go 0,1,2,3; q_shadow goes 1,0,1,0; acks at cycles 3,7,11,15.
//   S=R=1 never occurs.
//  Fairness: req=0011 held throughout -> grants alternate 0,1,0,1; no requester is starved.
//  Reset mid-pulse: assert rst_n=0 in cycle 2 of a set op -> latch_s=0 immediately, no ack.
//   After release, q_shadow=0 and rr_ptr=0.
//  Readback (macro on): tie latch_q=0, then issue a set -> err=1 from cycle 4, sticky.
//   A later correct op leaves err=1.

Source files
------------

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer that drives the S/R inputs of one SR latch with fixed-width pulses.
// Optional readback check of the latch Q output is enabled by defining SR_READBACK_CHECK_EN.
module sr_latch_ctrl #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1,
  localparam int unsigned IDW    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] ack,
  output logic             latch_s,
  output logic             latch_r,
  output logic             busy,
  output logic [IDW-1:0]   grant_id,
  output logic             q_shadow
`ifdef SR_READBACK_CHECK_EN
  ,
  input  logic             latch_q,
  output logic             err
`endif
);

  localparam int unsigned CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [N_REQ-1:0] ACK_ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             op_q;

  logic             found_c;
  logic [IDW-1:0]   winner_c;
  logic [IDW-1:0]   idx_c;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    idx_c    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx_c = IDW'((int'(rr_ptr) + i) % int'(N_REQ));
      if (!found_c && req[idx_c]) begin
        found_c  = 1'b1;
        winner_c = idx_c;
      end
    end
  end

  // Sequencer: S and R are only ever loaded from op_q and its complement, or both cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      op_q     <= 1'b0;
      ack      <= '0;
      latch_s  <= 1'b0;
      latch_r  <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      q_shadow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= '0;
          if (found_c) begin
            state    <= ST_PULSE;
            cnt      <= '0;
            grant_id <= winner_c;
            op_q     <= op[winner_c];
            latch_s  <= op[winner_c];
            latch_r  <= ~op[winner_c];
            busy     <= 1'b1;
            rr_ptr   <= IDW'((int'(winner_c) + 1) % int'(N_REQ));
          end
        end
        ST_PULSE: begin
          if (cnt == CNT_W'(PULSE_W - 1)) begin
            state    <= ST_RECOVER;
            cnt      <= '0;
            latch_s  <= 1'b0;
            latch_r  <= 1'b0;
            q_shadow <= op_q;
            ack      <= (GAP_W == 1) ? (ACK_ONE << grant_id) : '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RECOVER: begin
          if (cnt == CNT_W'(GAP_W - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ack   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Ack lands in the final recovery cycle.
            ack <= (GAP_W > 1 && cnt == CNT_W'(GAP_W - 2)) ? (ACK_ONE << grant_id) : '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          latch_s <= 1'b0;
          latch_r <= 1'b0;
          busy    <= 1'b0;
          ack     <= '0;
        end
      endcase
    end
  end

`ifdef SR_READBACK_CHECK_EN
  // Sticky compare of latch Q against the shadow in the first recovery cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == ST_RECOVER && cnt == '0 && latch_q != q_shadow) begin
      err <= 1'b1;
    end
  end
`endif

  a_no_invalid_sr: assert property (@(posedge clk) disable iff (!rst_n) !(latch_s && latch_r));

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl with a scoreboard of expected acks (N_REQ=4, PULSE_W=2, GAP_W=1).
// Exercises the readback path too when SR_READBACK_CHECK_EN is defined.
module tb_sr_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] op;
  logic [3:0] ack;
  logic       latch_s;
  logic       latch_r;
  logic       busy;
  logic [1:0] grant_id;
  logic       q_shadow;
`ifdef SR_READBACK_CHECK_EN
  logic       latch_q;
  logic       err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit auto_drop = 1'b0;

  typedef struct {
    int   id;
    logic op;
    int   cyc;
  } exp_t;
  exp_t sbq[$];

  sr_latch_ctrl #(.N_REQ(4), .PULSE_W(2), .GAP_W(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .op       (op),
    .ack      (ack),
    .latch_s  (latch_s),
    .latch_r  (latch_r),
    .busy     (busy),
    .grant_id (grant_id),
    .q_shadow (q_shadow)
`ifdef SR_READBACK_CHECK_EN
    ,
    .latch_q  (latch_q),
    .err      (err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic o, input int c);
    exp_t e;
    e.id  = id;
    e.op  = o;
    e.cyc = c;
    sbq.push_back(e);
  endtask

  // Advance to just after the next rising edge; optionally retire acked requests.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~ack;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s"}, 32'(latch_s), 32'd0);
    chk({tag, "_r"}, 32'(latch_r), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
  endtask

  // Scoreboard side: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("s_and_r", 32'(latch_s & latch_r), 32'd0);
      if (ack !== 4'b0000) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_vec", 32'(ack), 32'(4'b0001 << e.id));
          chk("ack_grant_id", 32'(grant_id), 32'(e.id));
          chk("ack_q_shadow", 32'(q_shadow), 32'(e.op));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    int b;
    rst_n = 1'b0;
    req   = 4'b0000;
    op    = 4'b0000;
`ifdef SR_READBACK_CHECK_EN
    latch_q = 1'b0;
`endif

    // Reset state, then idle with no requests.
    #7;
    check_idle_outputs("rst");
    chk("rst_q", 32'(q_shadow), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check_idle_outputs("idle");
    chk("idle_q", 32'(q_shadow), 32'd0);

    // Single set from requester 0.
    auto_drop = 1'b1;
    b = cyc;
    req = 4'b0001;
    op  = 4'b0001;
    push(0, 1'b1, b + 3);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("single_s_c%0d", k), 32'(latch_s), 32'(k == 1 || k == 2));
      chk($sformatf("single_r_c%0d", k), 32'(latch_r), 32'd0);
      chk($sformatf("single_busy_c%0d", k), 32'(busy), 32'(k <= 3));
      chk($sformatf("single_q_c%0d", k), 32'(q_shadow), 32'(k >= 3));
    end
    step();

    // Reset asserted in cycle 2 of a set op: abandoned, no ack.
    b = cyc;
    req = 4'b0001;
    op  = 4'b0001;
    step();
    step();
    chk("mid_s_before", 32'(latch_s), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    chk("mid_rst_q", 32'(q_shadow), 32'd0);
    req = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check_idle_outputs("post_rst");
    chk("post_rst_q", 32'(q_shadow), 32'd0);

    // Contention: all four request, alternating ops; rr_ptr restarts at 0.
    b = cyc;
    req = 4'b1111;
    op  = 4'b0101;
    push(0, 1'b1, b + 3);
    push(1, 1'b0, b + 7);
    push(2, 1'b1, b + 11);
    push(3, 1'b0, b + 15);
    repeat (17) step();
    chk("cont_drained", 32'(sbq.size()), 32'd0);
    chk("cont_req_left", 32'(req), 32'd0);

    // Fairness: two requesters hold req continuously.
    auto_drop = 1'b0;
    b = cyc;
    req = 4'b0011;
    op  = 4'b0001;
    push(0, 1'b1, b + 3);
    push(1, 1'b0, b + 7);
    push(0, 1'b1, b + 11);
    push(1, 1'b0, b + 15);
    repeat (15) step();
    req = 4'b0000;
    repeat (3) step();
    chk("fair_drained", 32'(sbq.size()), 32'd0);
    check_idle_outputs("fair_end");

`ifdef SR_READBACK_CHECK_EN
    // Readback: Q stuck at 0, a set raises err one cycle after the ack.
    rst_n = 1'b0;
    #2;
    chk("rb_rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    auto_drop = 1'b1;
    latch_q = 1'b0;
    b = cyc;
    req = 4'b0001;
    op  = 4'b0001;
    push(0, 1'b1, b + 3);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("rb_err_c%0d", k), 32'(err), 32'(k >= 4));
    end
    // A reset op now agrees with Q=0, but err stays set.
    b = cyc;
    req = 4'b0001;
    op  = 4'b0000;
    push(0, 1'b0, b + 3);
    repeat (5) step();
    chk("rb_err_sticky", 32'(err), 32'd1);
    chk("rb_drained", 32'(sbq.size()), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
